// File: rtl/encoder_8_3_seq_pkg.sv
// Shared types and constants for the sequential 8-to-3 encoder.
// The encoder reports the index of each set request bit, one code at a time.
package encoder_8_3_seq_pkg;

  localparam int unsigned N_IN   = 8;
  localparam int unsigned CODE_W = $clog2(N_IN);

  typedef enum logic {
    StIdle  = 1'b0,
    StDrain = 1'b1
  } state_e;

  // One-hot mask for a code; the same mapping decoder_3_8 uses.
  function automatic logic [N_IN-1:0] code_to_mask(input logic [CODE_W-1:0] code);
    logic [N_IN-1:0] mask;
    mask       = '0;
    mask[code] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/pri_enc_8_3.sv
// Combinational MSB-first priority encoder.
// It also reports whether any bit is set and whether exactly one bit is set.
module pri_enc_8_3
  import encoder_8_3_seq_pkg::*;
(
  input  logic [N_IN-1:0]   vec,
  output logic [CODE_W-1:0] code,
  output logic              any,
  output logic              single
);

  // The ascending scan lets the highest set bit win.
  always_comb begin
    code = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (vec[i]) begin
        code = i[CODE_W-1:0];
      end
    end
  end

  assign any    = |vec;
  assign single = any && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/encoder_8_3_seq.sv
// Sequential 8-to-3 encoder: loads a request vector and then emits the index of every set bit.
// Codes come out highest bit first, one per handshake.
module encoder_8_3_seq
  import encoder_8_3_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   req_in,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              code_last,
  output logic              zero_err
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   pending_q, pending_d, pending_next;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              zero_err_q, zero_err_d;

  logic [CODE_W-1:0] load_code, drain_code;
  logic              load_any, load_single, drain_any, drain_single;
  logic              handshake;

  assign handshake    = valid_q & code_ready;
  assign pending_next = pending_q & ~code_to_mask(code_q);

  pri_enc_8_3 u_load_enc (
    .vec    (req_in),
    .code   (load_code),
    .any    (load_any),
    .single (load_single)
  );

  pri_enc_8_3 u_drain_enc (
    .vec    (pending_next),
    .code   (drain_code),
    .any    (drain_any),
    .single (drain_single)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    code_d     = code_q;
    valid_d    = valid_q;
    last_d     = last_q;
    zero_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (load_any) begin
            state_d   = StDrain;
            pending_d = req_in;
            code_d    = load_code;
            valid_d   = 1'b1;
            last_d    = load_single;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        // req_valid is deliberately ignored until the vector is fully drained.
        if (handshake) begin
          pending_d = pending_next;
          if (drain_any) begin
            code_d = drain_code;
            last_d = drain_single;
          end else begin
            state_d = StIdle;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      code_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign code_last  = last_q;
  assign zero_err   = zero_err_q;

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Self-checking bench for encoder_8_3_seq: directed tables, corner sequences and a
// randomized round trip over every nonzero vector against a set-bit model.
module tb_encoder_8_3_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_in;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] code_out;
  logic       code_valid;
  logic       code_ready;
  logic       code_last;
  logic       zero_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encoder_8_3_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_last  (code_last),
    .zero_err   (zero_err)
  );

  typedef struct {
    logic [7:0]  vec;
    int          n;
    logic [23:0] codes;  // code j at [3*j +: 3]
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    req_in    = v;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_in    = 8'h00;
  endtask

  initial begin
    logic [2:0] q[$];
    logic [7:0] vv;
    logic [7:0] acc;
    logic [7:0] one;
    int         hs;
    int         budget;

    one        = 8'h01;
    rst        = 1'b1;
    req_in     = 8'h00;
    req_valid  = 1'b0;
    code_ready = 1'b1;

    tbl[0] = '{8'hA5, 4, {12'd0, 3'd0, 3'd2, 3'd5, 3'd7}};
    tbl[1] = '{8'h01, 1, {21'd0, 3'd0}};
    tbl[2] = '{8'h80, 1, {21'd0, 3'd7}};
    tbl[3] = '{8'h3C, 4, {12'd0, 3'd2, 3'd3, 3'd4, 3'd5}};
    tbl[4] = '{8'h42, 2, {18'd0, 3'd1, 3'd6}};

    // Reset state
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_code_out", 32'(code_out), 32'd0);
    check("rst_code_last", 32'(code_last), 32'd0);
    check("rst_zero_err", 32'(zero_err), 32'd0);
    rst = 1'b0;
    step();

    // Directed vectors, consumer always ready
    for (int t = 0; t < 5; t++) begin
      code_ready = 1'b1;
      load(tbl[t].vec);
      for (int j = 0; j < tbl[t].n; j++) begin
        check("tbl_valid", 32'(code_valid), 32'd1);
        check("tbl_code", 32'(code_out), 32'(tbl[t].codes[3*j +: 3]));
        check("tbl_last", 32'(code_last), 32'(j == tbl[t].n - 1));
        check("tbl_busy", 32'(req_ready), 32'd0);
        step();
      end
      check("tbl_done_valid", 32'(code_valid), 32'd0);
      check("tbl_done_last", 32'(code_last), 32'd0);
      check("tbl_done_ready", 32'(req_ready), 32'd1);
    end

    // Stall on 8'h81; a new request during DRAIN must be ignored
    code_ready = 1'b0;
    load(8'h81);
    req_in    = 8'hFF;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", 32'(code_valid), 32'd1);
      check("stall_code", 32'(code_out), 32'd7);
      check("stall_last", 32'(code_last), 32'd0);
      step();
    end
    req_valid  = 1'b0;
    req_in     = 8'h00;
    code_ready = 1'b1;
    check("stall_rel_code", 32'(code_out), 32'd7);
    step();
    check("stall_second_code", 32'(code_out), 32'd0);
    check("stall_second_last", 32'(code_last), 32'd1);
    check("stall_second_valid", 32'(code_valid), 32'd1);
    step();
    check("stall_done_valid", 32'(code_valid), 32'd0);
    check("stall_done_ready", 32'(req_ready), 32'd1);

    // All-zero vector
    load(8'h00);
    check("zero_err_pulse", 32'(zero_err), 32'd1);
    check("zero_valid", 32'(code_valid), 32'd0);
    check("zero_ready", 32'(req_ready), 32'd1);
    step();
    check("zero_err_clear", 32'(zero_err), 32'd0);
    check("zero_valid_after", 32'(code_valid), 32'd0);
    check("zero_ready_after", 32'(req_ready), 32'd1);

    // Async reset in the middle of draining 8'hFF
    load(8'hFF);
    check("ff_code0", 32'(code_out), 32'd7);
    step();
    check("ff_code1", 32'(code_out), 32'd6);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(code_valid), 32'd0);
    check("mid_rst_code", 32'(code_out), 32'd0);
    check("mid_rst_last", 32'(code_last), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    load(8'h02);
    check("reload_code", 32'(code_out), 32'd1);
    check("reload_last", 32'(code_last), 32'd1);
    check("reload_valid", 32'(code_valid), 32'd1);
    step();
    check("reload_done", 32'(code_valid), 32'd0);
    check("reload_ready", 32'(req_ready), 32'd1);

    // Round trip over every nonzero vector with random consumer back-pressure
    for (int v = 1; v < 256; v++) begin
      vv = v[7:0];
      q.delete();
      for (int b = 7; b >= 0; b--) begin
        if (vv[b]) q.push_back(3'(b));
      end
      acc    = 8'h00;
      hs     = 0;
      budget = 0;
      code_ready = 1'b0;
      load(vv);
      while (q.size() > 0 && budget < 200) begin
        check("rt_valid", 32'(code_valid), 32'd1);
        code_ready = 1'($urandom_range(0, 1));
        if (code_ready) begin
          check("rt_code", 32'(code_out), 32'(q[0]));
          check("rt_last", 32'(code_last), 32'(q.size() == 1));
          acc = acc | (one << code_out);
          hs++;
          void'(q.pop_front());
        end
        step();
        budget++;
      end
      if (budget >= 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL rt_timeout: vector %0h still has %0d codes, expected 0", vv, q.size());
      end
      code_ready = 1'b1;
      check("rt_end_valid", 32'(code_valid), 32'd0);
      check("rt_end_ready", 32'(req_ready), 32'd1);
      check("rt_accum", 32'(acc), 32'(vv));
      check("rt_handshakes", 32'(hs), 32'($countones(vv)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
